longop_wb_arbiter: RTL and testbench

Scoreboard and writeback-port arbiter for the two long-latency units (multi-cycle multiplier/divider and FPU).
- Tracks which architectural registers have an in-flight long-op result pending.
- Buffers each unit's completed result in a one-entry holding register.
- Shares the single register-file write port with the pipeline W stage.
- Drives decode-stage stall requests and a W-stage stall request to the hazard unit, so long ops retire without RAW/WAW hazards or port starvation.

---
 rtl/lo_pkg.sv | 18 +
 rtl/lo_result_buf.sv | 46 ++++
 rtl/longop_wb_arbiter.sv | 158 +++++++++++++++
 tb/tb_longop_wb_arbiter.sv | 253 +++++++++++++++++++++++++
 4 files changed

// File: rtl/lo_pkg.sv
// Shared types and constants for the long-op scoreboard and writeback arbiter.
package lo_pkg;

  localparam int unsigned REG_W     = 4;
  localparam int unsigned NUM_REGS  = 16;
  localparam int unsigned LO_DATA_W = 32;

  // Round-robin pointer encoding: which unit wins the next contended cycle.
  localparam logic UNIT_MC = 1'b0;
  localparam logic UNIT_FP = 1'b1;

  typedef struct packed {
    logic                 valid;
    logic [REG_W-1:0]     wa;
    logic [LO_DATA_W-1:0] data;
  } lo_buf_t;

endpackage

// File: rtl/lo_result_buf.sv
// One-entry holding register for a long-op result; ready whenever empty or
// being drained this cycle, so a new result can replace a granted one.
module lo_result_buf
  import lo_pkg::*;
#(
  parameter int unsigned DATA_W = LO_DATA_W
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              done_i,
  input  logic [DATA_W-1:0] res_i,
  input  logic [REG_W-1:0]  wa_i,
  input  logic              grant_i,
  output logic              ack_o,
  output logic              valid_o,
  output logic [REG_W-1:0]  wa_o,
  output logic [DATA_W-1:0] data_o
);

  lo_buf_t buf_q, buf_d;

  assign ack_o   = ~buf_q.valid | grant_i;
  assign valid_o = buf_q.valid;
  assign wa_o    = buf_q.wa;
  assign data_o  = DATA_W'(buf_q.data);

  always_comb begin
    buf_d = buf_q;
    if (done_i && ack_o) begin
      buf_d.valid = 1'b1;
      buf_d.wa    = wa_i;
      buf_d.data  = LO_DATA_W'(res_i);
    end else if (grant_i) begin
      buf_d.valid = 1'b0;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      buf_q <= '0;
    end else begin
      buf_q <= buf_d;
    end
  end

endmodule

// File: rtl/longop_wb_arbiter.sv
// Pending-register scoreboard and register-file write-port arbiter for the
// multi-cycle (MC) and FPU long-latency units, with starvation relief for W.
module longop_wb_arbiter
  import lo_pkg::*;
#(
  parameter int unsigned DATA_W       = 32,
  parameter int unsigned STARVE_LIMIT = 4
) (
  input  logic              CLK,
  input  logic              RESET,
  input  logic              IssueMC,
  input  logic [3:0]        IssueMCWA,
  input  logic              IssueFP,
  input  logic [3:0]        IssueFPWA,
  output logic              IssueStallMC,
  output logic              IssueStallFP,
  input  logic              DoneMC,
  input  logic [DATA_W-1:0] ResMC,
  input  logic [3:0]        WAMC,
  output logic              AckMC,
  input  logic              DoneFP,
  input  logic [DATA_W-1:0] ResFP,
  input  logic [3:0]        WAFP,
  output logic              AckFP,
  input  logic [3:0]        RA1D,
  input  logic [3:0]        RA2D,
  input  logic [3:0]        WA3D,
  input  logic              RegWriteW,
  output logic              PendStallD,
  output logic              WBStallReq,
  output logic              WE_LO,
  output logic [3:0]        WA_LO,
  output logic [DATA_W-1:0] WD_LO,
  output logic              LOBusy
);

  localparam int unsigned StarveW = $clog2(STARVE_LIMIT + 1);
  localparam logic [StarveW-1:0] StarveMax = StarveW'(STARVE_LIMIT);

  logic [NUM_REGS-1:0] pending_q, pending_d;
  logic                rr_q, rr_d;
  logic [StarveW-1:0]  starve_q, starve_d;
  logic                wbstall_q, wbstall_d;

  logic              mc_valid, fp_valid;
  logic [REG_W-1:0]  mc_wa, fp_wa;
  logic [DATA_W-1:0] mc_data, fp_data;
  logic              port_free, grant_mc, grant_fp;

  lo_result_buf #(
    .DATA_W (DATA_W)
  ) u_buf_mc (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .done_i  (DoneMC),
    .res_i   (ResMC),
    .wa_i    (WAMC),
    .grant_i (grant_mc),
    .ack_o   (AckMC),
    .valid_o (mc_valid),
    .wa_o    (mc_wa),
    .data_o  (mc_data)
  );

  lo_result_buf #(
    .DATA_W (DATA_W)
  ) u_buf_fp (
    .clk_i   (CLK),
    .rst_i   (RESET),
    .done_i  (DoneFP),
    .res_i   (ResFP),
    .wa_i    (WAFP),
    .grant_i (grant_fp),
    .ack_o   (AckFP),
    .valid_o (fp_valid),
    .wa_o    (fp_wa),
    .data_o  (fp_data)
  );

  // A same-cycle clear of the pending bit does not unblock issue; it retries next cycle.
  assign IssueStallMC = IssueMC & pending_q[IssueMCWA];
  assign IssueStallFP = IssueFP & (pending_q[IssueFPWA] |
                        (IssueMC & ~IssueStallMC & (IssueMCWA == IssueFPWA)));

  assign PendStallD = pending_q[RA1D] | pending_q[RA2D] | pending_q[WA3D];
  assign LOBusy     = (|pending_q) | mc_valid | fp_valid;
  assign WBStallReq = wbstall_q;

  assign port_free = ~RegWriteW | wbstall_q;
  assign grant_mc  = port_free & mc_valid & (~fp_valid | (rr_q == UNIT_MC));
  assign grant_fp  = port_free & fp_valid & (~mc_valid | (rr_q == UNIT_FP));

  always_comb begin
    WE_LO = grant_mc | grant_fp;
    WA_LO = '0;
    WD_LO = '0;
    if (grant_mc) begin
      WA_LO = mc_wa;
      WD_LO = mc_data;
    end else if (grant_fp) begin
      WA_LO = fp_wa;
      WD_LO = fp_data;
    end
  end

  always_comb begin
    pending_d = pending_q;
    if (grant_mc) pending_d[mc_wa] = 1'b0;
    if (grant_fp) pending_d[fp_wa] = 1'b0;
    if (IssueMC && !IssueStallMC) pending_d[IssueMCWA] = 1'b1;
    if (IssueFP && !IssueStallFP) pending_d[IssueFPWA] = 1'b1;

    rr_d = rr_q;
    if (mc_valid && fp_valid && WE_LO) begin
      rr_d = grant_mc ? UNIT_FP : UNIT_MC;
    end

    starve_d = starve_q;
    if (WE_LO || !(mc_valid || fp_valid)) begin
      starve_d = '0;
    end else if (RegWriteW && (starve_q != StarveMax)) begin
      starve_d = starve_q + 1'b1;
    end

    // Once asserted, the port is freed, so the stall only drops alongside a grant.
    wbstall_d = (starve_d == StarveMax);
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      pending_q <= '0;
      rr_q      <= UNIT_MC;
      starve_q  <= '0;
      wbstall_q <= 1'b0;
    end else begin
      pending_q <= pending_d;
      rr_q      <= rr_d;
      starve_q  <= starve_d;
      wbstall_q <= wbstall_d;
    end
  end

`ifndef SYNTHESIS
  a_mc_hold_done : assert property (@(posedge CLK) disable iff (RESET)
    (DoneMC && !AckMC) |=> DoneMC)
    else $error("DoneMC dropped while not acknowledged");
  a_fp_hold_done : assert property (@(posedge CLK) disable iff (RESET)
    (DoneFP && !AckFP) |=> DoneFP)
    else $error("DoneFP dropped while not acknowledged");
  a_mc_pending : assert property (@(posedge CLK) disable iff (RESET)
    mc_valid |-> pending_q[mc_wa])
    else $error("MC buffered result targets a non-pending register");
  a_fp_pending : assert property (@(posedge CLK) disable iff (RESET)
    fp_valid |-> pending_q[fp_wa])
    else $error("FP buffered result targets a non-pending register");
`endif

endmodule

// File: tb/tb_longop_wb_arbiter.sv
// Directed bench for longop_wb_arbiter: issue/retire, issue conflicts,
// round-robin contention, starvation relief, back-pressure and reset.
module tb_longop_wb_arbiter;

  logic        CLK = 1'b0;
  logic        RESET;
  logic        IssueMC, IssueFP;
  logic [3:0]  IssueMCWA, IssueFPWA;
  logic        IssueStallMC, IssueStallFP;
  logic        DoneMC, DoneFP;
  logic [31:0] ResMC, ResFP;
  logic [3:0]  WAMC, WAFP;
  logic        AckMC, AckFP;
  logic [3:0]  RA1D, RA2D, WA3D;
  logic        RegWriteW;
  logic        PendStallD, WBStallReq, WE_LO, LOBusy;
  logic [3:0]  WA_LO;
  logic [31:0] WD_LO;

  int checks = 0;
  int errors = 0;

  always #5 CLK = ~CLK;

  longop_wb_arbiter #(
    .DATA_W       (32),
    .STARVE_LIMIT (4)
  ) dut (
    .CLK          (CLK),
    .RESET        (RESET),
    .IssueMC      (IssueMC),
    .IssueMCWA    (IssueMCWA),
    .IssueFP      (IssueFP),
    .IssueFPWA    (IssueFPWA),
    .IssueStallMC (IssueStallMC),
    .IssueStallFP (IssueStallFP),
    .DoneMC       (DoneMC),
    .ResMC        (ResMC),
    .WAMC         (WAMC),
    .AckMC        (AckMC),
    .DoneFP       (DoneFP),
    .ResFP        (ResFP),
    .WAFP         (WAFP),
    .AckFP        (AckFP),
    .RA1D         (RA1D),
    .RA2D         (RA2D),
    .WA3D         (WA3D),
    .RegWriteW    (RegWriteW),
    .PendStallD   (PendStallD),
    .WBStallReq   (WBStallReq),
    .WE_LO        (WE_LO),
    .WA_LO        (WA_LO),
    .WD_LO        (WD_LO),
    .LOBusy       (LOBusy)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp)
    else begin
      errors++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Inputs change 1 time unit after the rising edge; checks follow 1 unit later.
  task automatic step();
    @(posedge CLK);
    #1;
  endtask

  // MC -> R1 and FP -> R2 captured together with the port free.
  task automatic contend(input logic [3:0] first_wa, input logic [3:0] second_wa);
    logic [31:0] first_d, second_d;
    first_d  = (first_wa == 4'd1) ? 32'h1111_0001 : 32'h2222_0002;
    second_d = (second_wa == 4'd1) ? 32'h1111_0001 : 32'h2222_0002;
    IssueMC = 1'b1; IssueMCWA = 4'd1; IssueFP = 1'b1; IssueFPWA = 4'd2;
    step();
    IssueMC = 1'b0; IssueFP = 1'b0;
    DoneMC = 1'b1; ResMC = 32'h1111_0001; WAMC = 4'd1;
    DoneFP = 1'b1; ResFP = 32'h2222_0002; WAFP = 4'd2;
    step();
    DoneMC = 1'b0; DoneFP = 1'b0;
    #1;
    check("rr_first_we", {31'd0, WE_LO}, 32'd1);
    check("rr_first_wa", {28'd0, WA_LO}, {28'd0, first_wa});
    check("rr_first_wd", WD_LO, first_d);
    step();
    #1;
    check("rr_second_wa", {28'd0, WA_LO}, {28'd0, second_wa});
    check("rr_second_wd", WD_LO, second_d);
    step();
    #1;
    check("rr_idle", {31'd0, LOBusy}, 32'd0);
  endtask

  initial begin
    RESET = 1'b1;
    IssueMC = 1'b0; IssueMCWA = '0; IssueFP = 1'b0; IssueFPWA = '0;
    DoneMC = 1'b0; ResMC = '0; WAMC = '0;
    DoneFP = 1'b0; ResFP = '0; WAFP = '0;
    RA1D = '0; RA2D = '0; WA3D = '0; RegWriteW = 1'b0;
    step();
    step();
    RESET = 1'b0;
    #1;
    check("rst_we", {31'd0, WE_LO}, 32'd0);
    check("rst_busy", {31'd0, LOBusy}, 32'd0);
    check("rst_wbstall", {31'd0, WBStallReq}, 32'd0);
    check("rst_pend", {31'd0, PendStallD}, 32'd0);
    check("rst_ackmc", {31'd0, AckMC}, 32'd1);

    // Single MC op to R4, port free.
    IssueMC = 1'b1; IssueMCWA = 4'd4;
    #1;
    check("mc_issue_ok", {31'd0, IssueStallMC}, 32'd0);
    step();
    IssueMC = 1'b0; RA1D = 4'd4;
    DoneMC = 1'b1; ResMC = 32'h1234_5678; WAMC = 4'd4;
    #1;
    check("mc_pend_set", {31'd0, PendStallD}, 32'd1);
    check("mc_busy", {31'd0, LOBusy}, 32'd1);
    check("mc_ack_empty", {31'd0, AckMC}, 32'd1);
    step();
    DoneMC = 1'b0;
    #1;
    check("mc_we", {31'd0, WE_LO}, 32'd1);
    check("mc_wa", {28'd0, WA_LO}, 32'd4);
    check("mc_wd", WD_LO, 32'h1234_5678);
    check("mc_pend_hold", {31'd0, PendStallD}, 32'd1);
    step();
    #1;
    check("mc_pend_clr", {31'd0, PendStallD}, 32'd0);
    check("mc_we_off", {31'd0, WE_LO}, 32'd0);
    check("mc_idle", {31'd0, LOBusy}, 32'd0);
    RA1D = 4'd0;

    // Same-cycle MC and FP issue to R3: FP refused until R3 retires.
    IssueMC = 1'b1; IssueMCWA = 4'd3; IssueFP = 1'b1; IssueFPWA = 4'd3;
    #1;
    check("waw_mc_ok", {31'd0, IssueStallMC}, 32'd0);
    check("waw_fp_stall", {31'd0, IssueStallFP}, 32'd1);
    step();
    IssueMC = 1'b0;
    DoneMC = 1'b1; ResMC = 32'hAAAA_0003; WAMC = 4'd3;
    #1;
    check("waw_fp_pend", {31'd0, IssueStallFP}, 32'd1);
    step();
    DoneMC = 1'b0;
    #1;
    check("waw_mc_wa", {28'd0, WA_LO}, 32'd3);
    check("waw_fp_clearing", {31'd0, IssueStallFP}, 32'd1);
    step();
    #1;
    check("waw_fp_go", {31'd0, IssueStallFP}, 32'd0);
    step();
    IssueFP = 1'b0; RA1D = 4'd3;
    DoneFP = 1'b1; ResFP = 32'hBBBB_0003; WAFP = 4'd3;
    #1;
    check("waw_fp_pending", {31'd0, PendStallD}, 32'd1);
    step();
    DoneFP = 1'b0;
    #1;
    check("waw_fp_wa", {28'd0, WA_LO}, 32'd3);
    check("waw_fp_wd", WD_LO, 32'hBBBB_0003);
    step();
    #1;
    check("waw_idle", {31'd0, LOBusy}, 32'd0);
    RA1D = 4'd0;

    // Starvation: MC result to R5 with W holding the port.
    IssueMC = 1'b1; IssueMCWA = 4'd5;
    step();
    IssueMC = 1'b0; RegWriteW = 1'b1;
    DoneMC = 1'b1; ResMC = 32'h0000_0055; WAMC = 4'd5;
    step();
    DoneMC = 1'b0;
    for (int i = 0; i < 4; i++) begin
      #1;
      check("starve_lost_we", {31'd0, WE_LO}, 32'd0);
      check("starve_lost_req", {31'd0, WBStallReq}, 32'd0);
      step();
    end
    #1;
    check("starve_req", {31'd0, WBStallReq}, 32'd1);
    check("starve_grant", {31'd0, WE_LO}, 32'd1);
    check("starve_wd", WD_LO, 32'h0000_0055);
    step();
    #1;
    check("starve_req_off", {31'd0, WBStallReq}, 32'd0);
    check("starve_we_off", {31'd0, WE_LO}, 32'd0);
    RegWriteW = 1'b0;

    // Back-pressure: BufMC full with R6, next result R7 must wait for the grant.
    IssueMC = 1'b1; IssueMCWA = 4'd6;
    step();
    IssueMCWA = 4'd7;
    step();
    IssueMC = 1'b0; RegWriteW = 1'b1;
    DoneMC = 1'b1; ResMC = 32'h0000_0066; WAMC = 4'd6;
    step();
    ResMC = 32'h0000_0077; WAMC = 4'd7;
    #1;
    check("bp_nack0", {31'd0, AckMC}, 32'd0);
    check("bp_nowe", {31'd0, WE_LO}, 32'd0);
    step();
    #1;
    check("bp_nack1", {31'd0, AckMC}, 32'd0);
    RegWriteW = 1'b0;
    #1;
    check("bp_ack", {31'd0, AckMC}, 32'd1);
    check("bp_wa6", {28'd0, WA_LO}, 32'd6);
    step();
    DoneMC = 1'b0;
    #1;
    check("bp_wa7", {28'd0, WA_LO}, 32'd7);
    check("bp_wd7", WD_LO, 32'h0000_0077);
    step();
    #1;
    check("bp_idle", {31'd0, LOBusy}, 32'd0);

    // Round-robin: MC first, then FP first, then MC first again.
    contend(4'd1, 4'd2);
    contend(4'd2, 4'd1);
    contend(4'd1, 4'd2);

    // Reset with both buffers full and R4/R5 pending; pointer currently favours FP.
    IssueMC = 1'b1; IssueMCWA = 4'd4; IssueFP = 1'b1; IssueFPWA = 4'd5;
    step();
    IssueMC = 1'b0; IssueFP = 1'b0; RegWriteW = 1'b1;
    DoneMC = 1'b1; ResMC = 32'hC0DE_0004; WAMC = 4'd4;
    DoneFP = 1'b1; ResFP = 32'hC0DE_0005; WAFP = 4'd5;
    step();
    DoneMC = 1'b0; DoneFP = 1'b0;
    #1;
    check("prerst_busy", {31'd0, LOBusy}, 32'd1);
    check("prerst_we", {31'd0, WE_LO}, 32'd0);
    RESET = 1'b1;
    step();
    RESET = 1'b0; RegWriteW = 1'b0; RA1D = 4'd4; RA2D = 4'd5;
    #1;
    check("postrst_we", {31'd0, WE_LO}, 32'd0);
    check("postrst_busy", {31'd0, LOBusy}, 32'd0);
    check("postrst_pend", {31'd0, PendStallD}, 32'd0);
    check("postrst_req", {31'd0, WBStallReq}, 32'd0);
    RA1D = 4'd0; RA2D = 4'd0;
    contend(4'd1, 4'd2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
